gemm_tile_loader: RTL and testbench
===================================

# gemm_tile_loader

Operand-side initiator for the `syn_tle` matrix-multiply core. It accepts a narrow, one-element-per-beat operand stream and assembles complete A (M×K), B (K×N) and C (M×N) tiles. It then presents each tile to the core's `A_i/B_i/C_i/valid_i/ready_o` input port under a valid/ready handshake. It sits between the operand DMA/stream fabric and the core, and also carries the per-tile halved-precision mode bit.

## Interface
- `M`, 2, rows of A/C/D
- `N`, 2, columns of B/C/D
- `K`, 2, inner dimension
- `P`, 8, operand element width in bits; C/D elements are 4·P
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `in_data_i` in 4·P: stream element (A/B use `[P-1:0]`, C uses all bits)
- `in_valid_i` in 1: stream beat valid
- `in_last_i` in 1: marks the final beat of a tile
- `in_mode_i` in 1: halved-precision mode, sampled on the first beat of a tile
- `in_ready_o` out 1: loader accepts a beat
- `A_o` out signed P × [M][K]: A tile to core
- `B_o` out signed P × [K][N]: B tile to core
- `C_o` out signed 4·P × [M][N]: C tile to core
- `halved_o` out 1: mode of the presented tile, drives core `halvedPrecision`
- `valid_o` out 1: tile valid, drives core `valid_i`
- `ready_i` in 1: core ready, driven from core `ready_o`
- `err_o` out 1: one-cycle pulse on a framing error

## Operation
- Tile length is T = M·K + K·N + M·N beats. Beat order: A row-major, then B row-major, then C row-major.
- Beat transfer: `in_valid_i && in_ready_o`. Tile transfer: `valid_o && ready_i`.
- Fill FSM states and transitions:
  - FILL_A: after M·K beats → FILL_B.
  - FILL_B: after K·N beats → FILL_C.
  - FILL_C: after M·N beats → tile complete.
  - PRESENT: used only in single-buffer builds.
  - A single element counter, 0..T-1, indexes the destination register.
- A/B elements are `in_data_i[P-1:0]` stored as-is. Upper bits are ignored, so 0x...80 stores as -128.
- `in_mode_i` is captured on beat 0 and travels with the tile.
- Framing check:
  - `in_last_i` on beat < T-1 → early last.
  - `in_last_i` low on beat T-1 → missing last.
  - Either case: `err_o` pulses the cycle after the offending beat, the partial tile is discarded, and the FSM returns to FILL_A with the counter at 0. The offending beat is consumed.
- Output data, `halved_o` and `valid_o` hold stable while `valid_o && !ready_i`.
- Reset values: `valid_o`=0, `err_o`=0, `halved_o`=0, `A_o/B_o/C_o`=0, FSM=FILL_A, counter=0.
  - `in_ready_o`=0 while `rst_i` is high.
  - `in_ready_o`=1 from the first cycle after deassertion.
- Reset mid-fill or mid-present discards everything. A tile that is not handshaken before reset is never presented.

## Timing
- Latency: `valid_o` rises the cycle after the last C beat is accepted.
- No combinational path from `ready_i` or `in_valid_i` to `in_ready_o`. `in_ready_o` is a function of registered state only.
- Single buffer:
  - `in_ready_o`=0 during PRESENT.
  - A tile transfer in cycle t returns the FSM to FILL_A at t+1, with `in_ready_o`=1.
  - Throughput: one tile per T+1 cycles with `ready_i`=1.
- Double buffer:
  - Full throughput is one tile per T cycles.
- Simultaneous final beat and tile transfer on the present buffer:
  - The new tile is presented next cycle with no bubble.

## Configuration
- `GEMM_TILE_LOADER_DOUBLE_BUF_EN` defined:
  - Separate fill and present buffers.
  - Filling continues while a tile is presented.
  - On fill completion, swap if the present buffer is empty or handshaking that cycle. Otherwise hold the full fill buffer with `in_ready_o`=0 until the present tile transfers, then swap on the next cycle.
- Undefined:
  - Single register set plus the PRESENT state.
  - No overlap between filling and presenting.

## Structure
- Shared package `gemm_pkg`:
  - Default M/N/K/P constants.
  - Tile typedefs `a_tile_t`, `b_tile_t`, `c_tile_t` (parameterised widths via localparams in the module).
  - Fill state enum `fill_state_e`.
- Sub-module `gemm_tile_buf`: one A/B/C/mode register set with a write port (phase, index, data). It is instantiated once, or twice under `GEMM_TILE_LOADER_DOUBLE_BUF_EN`.

## Test plan
Configuration for all scenarios: M=N=K=2, P=8, T=12.
- Basic tile: A beats=1, B beats=2, C beats=3, `in_last_i` on beat 11, `ready_i`=1 → `valid_o` one cycle after beat 11; `A_o` all 1, `B_o` all 2, `C_o` all 3; `halved_o`=0.
- Backpressure: `ready_i`=0 for 20 cycles, stream always valid → outputs stable throughout.
  - Single buffer: `in_ready_o`=0 throughout.
  - Double buffer: exactly 12 more beats accepted, then `in_ready_o`=0.
  - On `ready_i`=1, the second tile follows next cycle.
- Framing: `in_last_i` on beat 4 → `err_o` pulses once and no `valid_o`; the next 12 beats produce a correct tile.
- Mode and sign: `in_mode_i`=1 on beat 0, A beats=0xFFFFFF80 → `halved_o`=1, `A_o` elements=-128.
- Reset mid-fill: `rst_i` high for 1 cycle after beat 6 → `in_ready_o`=0 during reset and no `valid_o`; the following 12-beat tile is correct.
- Back-to-back: 4 tiles, `ready_i`=1.
  - Double buffer: `valid_o` pulses every 12 cycles.
  - Single buffer: `valid_o` pulses every 13 cycles.

Source files
------------

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared GEMM tile sizes, tile types and fill-state encoding
package gemm_pkg;
  localparam int GEMM_M = 2;
  localparam int GEMM_N = 2;
  localparam int GEMM_K = 2;
  localparam int GEMM_P = 8;
  typedef logic signed [GEMM_M-1:0][GEMM_K-1:0][GEMM_P-1:0] a_tile_t;
  typedef logic signed [GEMM_K-1:0][GEMM_N-1:0][GEMM_P-1:0] b_tile_t;
  typedef logic signed [GEMM_M-1:0][GEMM_N-1:0][4*GEMM_P-1:0] c_tile_t;
  typedef enum logic [1:0] {FILL_A, FILL_B, FILL_C, PRESENT} fill_state_e;
endpackage

// File: rtl/gemm_tile_buf.sv
// gemm_tile_buf: one A/B/C tile register set plus its mode bit, written one element at a time
module gemm_tile_buf
  import gemm_pkg::*;
#(
  parameter int M = GEMM_M,
  parameter int N = GEMM_N,
  parameter int K = GEMM_K,
  parameter int P = GEMM_P,
  parameter int IW = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                we_i,
  input  fill_state_e                         phase_i,
  input  logic [IW-1:0]                       idx_i,
  input  logic [4*P-1:0]                      data_i,
  input  logic                                mode_we_i,
  input  logic                                mode_i,
  output logic signed [M-1:0][K-1:0][P-1:0]   A_o,
  output logic signed [K-1:0][N-1:0][P-1:0]   B_o,
  output logic signed [M-1:0][N-1:0][4*P-1:0] C_o,
  output logic                                halved_o
);
  logic [M*K-1:0][P-1:0] a_q;
  logic [K*N-1:0][P-1:0] b_q;
  logic [M*N-1:0][4*P-1:0] c_q;
  // each write lands in the row-major slot chosen by phase and index
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      halved_o <= 1'b0;
    end else begin
      for (int i = 0; i < M*K; i++) if (we_i && phase_i == FILL_A && idx_i == IW'(i)) a_q[i] <= data_i[P-1:0];
      for (int i = 0; i < K*N; i++) if (we_i && phase_i == FILL_B && idx_i == IW'(i)) b_q[i] <= data_i[P-1:0];
      for (int i = 0; i < M*N; i++) if (we_i && phase_i == FILL_C && idx_i == IW'(i)) c_q[i] <= data_i;
      if (mode_we_i) halved_o <= mode_i;
    end
  end
  assign A_o = a_q;
  assign B_o = b_q;
  assign C_o = c_q;
endmodule

// File: rtl/gemm_tile_loader.sv
// gemm_tile_loader: assembles A/B/C operand tiles from a one-element-per-beat stream and presents them to the GEMM core
// GEMM_TILE_LOADER_DOUBLE_BUF_EN: fill the next tile in a second buffer while the current one is presented
module gemm_tile_loader
  import gemm_pkg::*;
#(
  parameter int M = GEMM_M,
  parameter int N = GEMM_N,
  parameter int K = GEMM_K,
  parameter int P = GEMM_P
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [4*P-1:0]                      in_data_i,
  input  logic                                in_valid_i,
  input  logic                                in_last_i,
  input  logic                                in_mode_i,
  output logic                                in_ready_o,
  output logic signed [M-1:0][K-1:0][P-1:0]   A_o,
  output logic signed [K-1:0][N-1:0][P-1:0]   B_o,
  output logic signed [M-1:0][N-1:0][4*P-1:0] C_o,
  output logic                                halved_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic                                err_o
);
  localparam int MK = M * K;
  localparam int KN = K * N;
  localparam int T = MK + KN + M * N;
  localparam int CW = $clog2(T);
  fill_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, idx;
  logic err_q, beat, at_end, bad, done;
  assign beat = in_valid_i && in_ready_o;
  assign at_end = cnt_q == CW'(T - 1);
  assign bad = beat && (in_last_i != at_end);
  assign done = beat && at_end && in_last_i;
  assign idx = state_q == FILL_A ? cnt_q : state_q == FILL_B ? cnt_q - CW'(MK) : cnt_q - CW'(MK + KN);
`ifdef GEMM_TILE_LOADER_DOUBLE_BUF_EN
  localparam fill_state_e DONE_ST = FILL_A;
  logic wr_sel_q, wr_sel_d, valid_q, valid_d, held_q, held_d, swap;
  logic signed [M-1:0][K-1:0][P-1:0] a_b [2];
  logic signed [K-1:0][N-1:0][P-1:0] b_b [2];
  logic signed [M-1:0][N-1:0][4*P-1:0] c_b [2];
  logic h_b [2];
  for (genvar g = 0; g < 2; g++) begin : g_buf
    gemm_tile_buf #(.M(M), .N(N), .K(K), .P(P), .IW(CW)) u_buf (
      .clk_i(clk_i), .rst_i(rst_i), .we_i(beat && wr_sel_q == 1'(g)), .phase_i(state_q), .idx_i(idx),
      .data_i(in_data_i), .mode_we_i(beat && wr_sel_q == 1'(g) && cnt_q == '0), .mode_i(in_mode_i),
      .A_o(a_b[g]), .B_o(b_b[g]), .C_o(c_b[g]), .halved_o(h_b[g])
    );
  end
  // swap in the filled buffer when the presented one is empty or leaving this cycle
  always_comb begin
    swap = (done && (!valid_q || ready_i)) || (held_q && ready_i);
    held_d = held_q ? !ready_i : done && !swap;
    valid_d = swap || (valid_q && !ready_i);
    wr_sel_d = wr_sel_q ^ swap;
  end
  // present-side registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_sel_q <= 1'b0;
      valid_q <= 1'b0;
      held_q <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      valid_q <= valid_d;
      held_q <= held_d;
    end
  end
`else
  localparam fill_state_e DONE_ST = PRESENT;
  gemm_tile_buf #(.M(M), .N(N), .K(K), .P(P), .IW(CW)) u_buf (
    .clk_i(clk_i), .rst_i(rst_i), .we_i(beat), .phase_i(state_q), .idx_i(idx),
    .data_i(in_data_i), .mode_we_i(beat && cnt_q == '0), .mode_i(in_mode_i),
    .A_o(A_o), .B_o(B_o), .C_o(C_o), .halved_o(halved_o)
  );
`endif
  // fill state, element counter and framing-error pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL_A;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= bad;
    end
  end
  // advance per accepted beat; a framing error drops the partial tile and restarts at FILL_A
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (bad) begin
      state_d = FILL_A;
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = at_end ? '0 : cnt_q + CW'(1);
      state_d = at_end ? DONE_ST : cnt_q == CW'(MK - 1) ? FILL_B : cnt_q == CW'(MK + KN - 1) ? FILL_C : state_q;
    end else if (state_q == PRESENT && ready_i) begin
      state_d = FILL_A;
    end
  end
  // handshake outputs depend only on registered state (and reset)
  always_comb begin
    err_o = err_q;
`ifdef GEMM_TILE_LOADER_DOUBLE_BUF_EN
    in_ready_o = !rst_i && !held_q;
    valid_o = valid_q;
    A_o = wr_sel_q ? a_b[0] : a_b[1];
    B_o = wr_sel_q ? b_b[0] : b_b[1];
    C_o = wr_sel_q ? c_b[0] : c_b[1];
    halved_o = wr_sel_q ? h_b[0] : h_b[1];
`else
    in_ready_o = !rst_i && state_q != PRESENT;
    valid_o = state_q == PRESENT;
`endif
  end
endmodule

// File: tb/tb_gemm_tile_loader.sv
// tb_gemm_tile_loader: directed stimulus checked against a tile-level scoreboard model of the loader
module tb_gemm_tile_loader;
  import gemm_pkg::*;
  localparam int M = 2, N = 2, K = 2, P = 8, T = M*K + K*N + M*N;
`ifdef GEMM_TILE_LOADER_DOUBLE_BUF_EN
  localparam int DEPTH = 2, PERIOD = 12, BP_BEATS = 12;
`else
  localparam int DEPTH = 1, PERIOD = 13, BP_BEATS = 0;
`endif
  typedef struct {
    a_tile_t a;
    b_tile_t b;
    c_tile_t c;
    logic h;
  } tile_t;
  logic clk = 0, rst_i = 1, in_valid_i = 0, in_last_i = 0, in_mode_i = 0, ready_i = 0;
  logic [31:0] in_data_i = '0;
  logic in_ready_o, halved_o, valid_o, err_o;
  a_tile_t A_o;
  b_tile_t B_o;
  c_tile_t C_o;
  tile_t q[$];
  tile_t nt;
  logic [31:0] cur[$];
  logic [31:0] mw;
  logic cur_mode = 0, err_pend = 0, go = 0;
  int total = 0, bad = 0, cyc = 0, acc = 0;
  int xfers[$];

  gemm_tile_loader dut (
    .clk_i(clk), .rst_i(rst_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_last_i(in_last_i),
    .in_mode_i(in_mode_i), .in_ready_o(in_ready_o), .A_o(A_o), .B_o(B_o), .C_o(C_o),
    .halved_o(halved_o), .valid_o(valid_o), .ready_i(ready_i), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input logic mode);
    int w = 0;
    in_valid_i = 1;
    in_data_i = d;
    in_last_i = last;
    in_mode_i = mode;
    @(negedge clk);
    while (!in_ready_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready_o) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: in_ready_o %0b required 1 within 200 cycles", in_ready_o);
    end
    sync();
    in_valid_i = 0;
    in_last_i = 0;
  endtask

  // mode is driven only on beat 0; the other beats carry the opposite value
  task automatic send_tile(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic mode, input logic ramp, input int nb, input int last_at);
    for (int i = 0; i < nb; i++)
      beat((i < M*K ? a : i < M*K + K*N ? b : c) + (ramp ? 32'(i * 17) : 32'd0), i == last_at, i == 0 ? mode : !mode);
  endtask

  // scoreboard: completed tiles queue up until handshaken; outputs checked every cycle
  always @(negedge clk) if (go) begin
    chk("in_ready", in_ready_o, !rst_i && q.size() < DEPTH);
    chk("valid", valid_o, q.size() > 0);
    chk("err", err_o, err_pend);
    if (valid_o && q.size() > 0) begin
      chk("tile_a", $unsigned(A_o), $unsigned(q[0].a));
      chk("tile_b", $unsigned(B_o), $unsigned(q[0].b));
      chk("tile_c", $unsigned(C_o), $unsigned(q[0].c));
      chk("tile_halved", halved_o, q[0].h);
    end
    if (rst_i) begin
      q.delete();
      cur.delete();
      err_pend = 0;
    end else begin
      err_pend = 0;
      if (valid_o && ready_i && q.size() > 0) begin
        void'(q.pop_front());
        xfers.push_back(cyc);
      end
      if (in_valid_i && in_ready_o) begin
        cur.push_back(in_data_i);
        if (cur.size() == 1) cur_mode = in_mode_i;
        if (in_last_i || cur.size() == T) begin
          if (in_last_i && cur.size() == T) begin
            for (int r = 0; r < M; r++)
              for (int k = 0; k < K; k++) begin
                mw = cur[r*K + k];
                nt.a[r][k] = mw[P-1:0];
              end
            for (int k = 0; k < K; k++)
              for (int n = 0; n < N; n++) begin
                mw = cur[M*K + k*N + n];
                nt.b[k][n] = mw[P-1:0];
              end
            for (int r = 0; r < M; r++)
              for (int n = 0; n < N; n++) nt.c[r][n] = cur[M*K + K*N + r*N + n];
            nt.h = cur_mode;
            q.push_back(nt);
          end else err_pend = 1;
          cur.delete();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready_o, 0);
    sync();
    rst_i = 0;
    @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_halved", halved_o, 0);
    chk("rst_a", $unsigned(A_o), 0);
    chk("rst_b", $unsigned(B_o), 0);
    chk("rst_c", $unsigned(C_o), 0);
    chk("post_rst_in_ready", in_ready_o, 1);
    sync();
    go = 1;
    ready_i = 1;
    // basic tile
    send_tile(32'd1, 32'd2, 32'd3, 0, 0, 12, 11);
    @(negedge clk);
    chk("basic_latency_valid", valid_o, 1);
    chk("basic_a", $unsigned(A_o), 32'h01010101);
    chk("basic_b", $unsigned(B_o), 32'h02020202);
    chk("basic_c", $unsigned(C_o), {32'd3, 32'd3, 32'd3, 32'd3});
    chk("basic_halved", halved_o, 0);
    sync();
    // early last on beat 4
    send_tile(32'd7, 32'd8, 32'd9, 0, 0, 5, 4);
    @(negedge clk);
    chk("early_err", err_o, 1);
    chk("early_no_valid", valid_o, 0);
    @(negedge clk);
    chk("early_err_once", err_o, 0);
    sync();
    send_tile(32'h11, 32'h22, 32'h33, 0, 1, 12, 11);
    // missing last on beat 11
    send_tile(32'h44, 32'h55, 32'h66, 1, 1, 12, -1);
    @(negedge clk);
    chk("missing_err", err_o, 1);
    sync();
    send_tile(32'h21, 32'h42, 32'h1234_5678, 1, 1, 12, 11);
    // halved mode and sign handling
    send_tile(32'hFFFFFF80, 32'h7F, 32'h89ABCDEF, 1, 0, 12, 11);
    @(negedge clk);
    chk("mode_halved", halved_o, 1);
    chk("mode_a", $unsigned(A_o), 32'h80808080);
    chk("mode_a_neg", 128'($signed(A_o[1][1])), 128'(-128));
    chk("mode_b", $unsigned(B_o), 32'h7F7F7F7F);
    chk("mode_c", $unsigned(C_o), {4{32'h89ABCDEF}});
    sync();
    // reset mid-fill after beat 6
    send_tile(32'h5, 32'h6, 32'h7, 0, 1, 7, -1);
    rst_i = 1;
    in_valid_i = 1;
    @(negedge clk);
    chk("midfill_rst_in_ready", in_ready_o, 0);
    sync();
    rst_i = 0;
    in_valid_i = 0;
    send_tile(32'h61, 32'h72, 32'h83, 1, 1, 12, 11);
    @(negedge clk);
    chk("after_rst_valid", valid_o, 1);
    sync();
    // reset while a tile is being presented
    ready_i = 0;
    send_tile(32'h9, 32'hA, 32'hB, 0, 1, 12, 11);
    rst_i = 1;
    sync();
    rst_i = 0;
    @(negedge clk);
    chk("present_rst_dropped", valid_o, 0);
    sync();
    // backpressure: ready low for 20 cycles with the stream always valid
    send_tile(32'h10, 32'h20, 32'h30, 0, 1, 12, 11);
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid_i = 1;
      in_data_i = 32'h50 + 32'(acc);
      in_last_i = acc == 11;
      in_mode_i = 0;
      @(negedge clk);
      if (in_ready_o) acc++;
      sync();
    end
    in_valid_i = 0;
    in_last_i = 0;
    chk("bp_accepted", acc, BP_BEATS);
    ready_i = 1;
    @(negedge clk);
    sync();
    @(negedge clk);
`ifdef GEMM_TILE_LOADER_DOUBLE_BUF_EN
    chk("bp_next_valid", valid_o, 1);
    chk("bp_next_c00", C_o[0][0], 32'h58);
`else
    chk("bp_next_valid", valid_o, 0);
    chk("bp_next_in_ready", in_ready_o, 1);
`endif
    sync();
    repeat (3) sync();
    // back-to-back tiles
    xfers.delete();
    for (int t = 0; t < 4; t++) send_tile(32'h3 + 32'(t), 32'h40 + 32'(t), 32'h700 + 32'(t), t[0], 1, 12, 11);
    repeat (3) sync();
    chk("b2b_count", xfers.size(), 4);
    for (int i = 0; i + 1 < xfers.size(); i++) chk("b2b_period", xfers[i+1] - xfers[i], PERIOD);
    @(negedge clk);
    chk("drained", valid_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
